signal_switch_ctrl: RTL and testbench
=====================================

Name: signal_switch_ctrl

Overview:
- Sequenced front end for the A/B stream swap: samples a quasi-static swap request and performs the swap only on a frame boundary.
- Blanks both outputs for a programmable mute interval around the swap, so downstream FFT/demodulation never sees a mixed frame.
- Sits between the AXI-lite configuration register (swap request) and the two ADC sample streams feeding the processing chain.
- Registered datapath; exports the applied swap state for status readback.

Parameters:
- DATA_WIDTH, 16, sample width of a, b, x, y.
- MUTE_CYCLES, 8, number of cycles x and y are forced to zero during a swap; legal range 1..2**CNT_WIDTH-1.
- CNT_WIDTH, 8, width of the mute counter.

Ports:
- SYS_aclk  in  1  system clock; all logic rising-edge.
- SYS_areset  in  1  asynchronous, active-high reset.
- switch_req  in  1  requested swap state from the config register; level, quasi-static.
- frame_start  in  1  single-cycle strobe marking the first sample of a frame.
- a  in  DATA_WIDTH  stream A sample, one per cycle.
- b  in  DATA_WIDTH  stream B sample, one per cycle.
- x  out  DATA_WIDTH  registered output: a when switch_state=0, b when 1; zero while muted.
- y  out  DATA_WIDTH  registered output: b when switch_state=0, a when 1; zero while muted.
- switch_state  out  1  currently applied swap state.
- busy  out  1  high in ARMED or MUTE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, switch_state=0, x=0, y=0, busy=0, counter=0.
- Datapath latency is 1 cycle: x/y at edge n+1 reflect a/b at edge n and the state/switch_state at edge n.
- IDLE:
  - If switch_req != switch_state, go to ARMED; busy=1 from the next cycle.
  - Otherwise stay in IDLE and pass data.
- ARMED:
  - Data still passes with the old switch_state.
  - If switch_req == switch_state again, return to IDLE (request cancelled, no mute).
  - Else, on frame_start=1, go to MUTE, load counter=MUTE_CYCLES-1, and latch target = switch_req.
  - Cancel has priority over frame_start in the same cycle.
- MUTE:
  - x=y=0 on every output cycle whose input sample was taken in MUTE; the counter decrements each cycle.
  - When counter==0: switch_state <= target and go to IDLE.
  - The first unmuted output uses the new switch_state.
  - Mute length on x/y is exactly MUTE_CYCLES samples.
  - switch_req changes during MUTE are ignored; IDLE re-evaluates them on the following cycle, which may start a new ARMED immediately.
- frame_start in IDLE or MUTE has no effect.
- A frame_start on the same cycle as the IDLE->ARMED transition is not used; ARMED waits for the next strobe.
- Reset mid-MUTE: immediately returns to reset values; the swap is lost, and switch_state=0 regardless of target.
- busy is a registered function of state: 1 in ARMED/MUTE, else 0.
- No arithmetic on data; counter decrement only, with no wrap (it leaves MUTE at 0).

Decomposition:
- Shared package for the state encoding (IDLE=2'd0, ARMED=2'd1, MUTE=2'd2) and the default widths, reused by status-register decode.
- Sub-module: the existing combinational A/B swap block, instanced for the a/b routing.
- The controller adds the FSM, the mute gating and the output registers around it.
- No further hierarchy.

Test Plan:
- Reset, a=16'h1111, b=16'h2222, switch_req=0 -> after one cycle x=16'h1111, y=16'h2222, switch_state=0, busy=0.
- Raise switch_req with no frame_start for 20 cycles -> busy=1, x/y unchanged; pulse frame_start -> x=y=0 for exactly 8 samples, then x=16'h2222, y=16'h1111, switch_state=1, busy=0.
- Raise switch_req, drop it before any frame_start -> busy returns to 0, no mute samples, switch_state stays 0.
- Raise switch_req, then drop it on the same cycle as frame_start -> cancel wins: no mute, switch_state=0.
- During MUTE toggle switch_req back to 0 -> swap completes (switch_state=1), then busy re-asserts the cycle after IDLE; the next frame_start performs a second 8-cycle mute back to switch_state=0.
- Assert SYS_areset at mute cycle 3 -> x=y=0, switch_state=0, busy=0 immediately; after release with switch_req=1, ARMED is entered on the first cycle.

Source files
------------

// File: rtl/signal_switch_ctrl_pkg.sv
// Shared definitions for the A/B stream swap controller.
// - state_t: controller state encoding, also used by the status-register decode.
// - DEFAULT_*: default widths and mute length for the controller and its interface.
// - state_is_busy(): maps a state to the exported busy flag.
package signal_switch_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_MUTE_CYCLES = 8;
  localparam int DEFAULT_CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_MUTE  = 2'd2
  } state_t;

  function automatic logic state_is_busy(input state_t s);
    return (s == ST_ARMED) || (s == ST_MUTE);
  endfunction

endpackage

// File: rtl/signal_switch_ctrl_if.sv
// Signal bundle between the swap controller and its surroundings.
// Ports:
//   switch_req   - requested swap state (level, quasi-static)
//   frame_start  - one-cycle strobe on the first sample of a frame
//   a, b         - input sample streams
//   x, y         - routed and mute-gated output samples
//   switch_state - currently applied swap state
//   busy         - a swap is pending or in progress
// Modports: master drives the request and the samples; slave is the controller.
interface signal_switch_ctrl_if
  import signal_switch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  switch_req;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] y;
  logic                  switch_state;
  logic                  busy;

  modport master (
    output switch_req, frame_start, a, b,
    input  x, y, switch_state, busy
  );

  modport slave (
    input  switch_req, frame_start, a, b,
    output x, y, switch_state, busy
  );

endinterface

// File: rtl/signal_switch_ctrl_swap.sv
// Combinational A/B swap.
// Ports:
//   sel  - 0: x=a, y=b; 1: x=b, y=a
//   a, b - input samples
//   x, y - routed samples
module signal_switch_ctrl_swap
  import signal_switch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  assign x = sel ? b : a;
  assign y = sel ? a : b;

endmodule

// File: rtl/signal_switch_ctrl.sv
// Frame-aligned A/B stream swap controller.
// A change of switch_req arms the controller; the next frame_start starts a
// mute window of MUTE_CYCLES samples, at the end of which the new swap state
// is applied, so no output frame mixes the two routings.
// Ports:
//   SYS_aclk   - system clock, rising edge
//   SYS_areset - asynchronous active-high reset
//   sw         - slave side of signal_switch_ctrl_if (request, samples, status)
// MUTE_CYCLES must lie in 1..2**CNT_WIDTH-1.
module signal_switch_ctrl
  import signal_switch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MUTE_CYCLES = DEFAULT_MUTE_CYCLES,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input logic                 SYS_aclk,
  input logic                 SYS_areset,
  signal_switch_ctrl_if.slave sw
);

  // The counter counts MUTE_CYCLES-1 down to 0, one mute sample per value.
  localparam logic [CNT_WIDTH-1:0] MUTE_LOAD = CNT_WIDTH'(MUTE_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   counter_reg, counter_next;
  logic                   target_reg, target_next;
  logic                   switch_state_reg, switch_state_next;
  logic                   busy_reg, busy_next;
  logic [DATA_WIDTH-1:0]  x_reg, x_next;
  logic [DATA_WIDTH-1:0]  y_reg, y_next;
  logic [DATA_WIDTH-1:0]  route_x, route_y;

  signal_switch_ctrl_swap #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_swap (
    .sel (switch_state_reg),
    .a   (sw.a),
    .b   (sw.b),
    .x   (route_x),
    .y   (route_y)
  );

  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      state_reg        <= ST_IDLE;
      counter_reg      <= '0;
      target_reg       <= 1'b0;
      switch_state_reg <= 1'b0;
      busy_reg         <= 1'b0;
      x_reg            <= '0;
      y_reg            <= '0;
    end else begin
      state_reg        <= state_next;
      counter_reg      <= counter_next;
      target_reg       <= target_next;
      switch_state_reg <= switch_state_next;
      busy_reg         <= busy_next;
      x_reg            <= x_next;
      y_reg            <= y_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    counter_next      = counter_reg;
    target_next       = target_reg;
    switch_state_next = switch_state_reg;

    case (state_reg)
      ST_IDLE: begin
        // A frame_start seen here is deliberately ignored, even on the
        // arming cycle itself.
        if (sw.switch_req != switch_state_reg) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Cancellation wins over a coincident frame_start.
        if (sw.switch_req == switch_state_reg) begin
          state_next = ST_IDLE;
        end else if (sw.frame_start) begin
          state_next   = ST_MUTE;
          counter_next = MUTE_LOAD;
          target_next  = sw.switch_req;
        end
      end
      ST_MUTE: begin
        if (counter_reg == '0) begin
          switch_state_next = target_reg;
          state_next        = ST_IDLE;
        end else begin
          counter_next = counter_reg - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // busy follows the state being entered, so it is aligned with state_reg.
    busy_next = state_is_busy(state_next);

    // Samples taken while muting are blanked; the routing uses the swap
    // state in force when the sample is taken.
    if (state_reg == ST_MUTE) begin
      x_next = '0;
      y_next = '0;
    end else begin
      x_next = route_x;
      y_next = route_y;
    end
  end

  assign sw.x            = x_reg;
  assign sw.y            = y_reg;
  assign sw.switch_state = switch_state_reg;
  assign sw.busy         = busy_reg;

endmodule

// File: tb/tb_signal_switch_ctrl.sv
// Testbench for signal_switch_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a frame-level model.
module tb_signal_switch_ctrl;

  localparam int DW = 16;
  localparam int M  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  signal_switch_ctrl_if #(.DATA_WIDTH(DW)) sw ();

  signal_switch_ctrl #(
    .DATA_WIDTH  (DW),
    .MUTE_CYCLES (M),
    .CNT_WIDTH   (8)
  ) dut (
    .SYS_aclk   (clk),
    .SYS_areset (rst),
    .sw         (sw)
  );

  typedef struct {
    logic          req;
    logic          fs;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] ex;
    logic [DW-1:0] ey;
    logic          ess;
    logic          ebusy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: a pending request, a number of blanked samples
  // still owed, and the routing currently applied.
  logic m_applied;
  logic m_pending;
  logic m_target;
  int   m_mute_left;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [DW-1:0] ex, input logic [DW-1:0] ey,
                         input logic ess, input logic ebusy);
    chk({name, ".x"}, sw.x, ex);
    chk({name, ".y"}, sw.y, ey);
    chk({name, ".switch_state"}, {15'd0, sw.switch_state}, {15'd0, ess});
    chk({name, ".busy"}, {15'd0, sw.busy}, {15'd0, ebusy});
  endtask

  task automatic drive(input logic req, input logic fs, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    sw.switch_req  = req;
    sw.frame_start = fs;
    sw.a           = av;
    sw.b           = bv;
  endtask

  task automatic cycle(input logic req, input logic fs, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    drive(req, fs, av, bv);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk_all("reset", '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_applied   = 1'b0;
    m_pending   = 1'b0;
    m_target    = 1'b0;
    m_mute_left = 0;
  endtask

  // Computes what the outputs must show after the coming edge, then
  // advances the model by one sample.
  task automatic model_step(input logic req, input logic fs, input logic [DW-1:0] av,
                            input logic [DW-1:0] bv, output logic [DW-1:0] ex,
                            output logic [DW-1:0] ey, output logic ess, output logic ebusy);
    if (m_mute_left > 0) begin
      ex = '0;
      ey = '0;
      m_mute_left--;
      if (m_mute_left == 0) m_applied = m_target;
    end else begin
      ex = m_applied ? bv : av;
      ey = m_applied ? av : bv;
      if (m_pending) begin
        if (req == m_applied) begin
          m_pending = 1'b0;
        end else if (fs) begin
          m_pending   = 1'b0;
          m_target    = req;
          m_mute_left = M;
        end
      end else if (req != m_applied) begin
        m_pending = 1'b1;
      end
    end
    ess   = m_applied;
    ebusy = m_pending || (m_mute_left > 0);
  endtask

  vec_t vecs[16];

  initial begin
    logic [DW-1:0] rx, ry, ra, rb;
    logic          ress, rbusy, rreq, rfs;

    // Main swap scenario, one row per clock.
    vecs[0] = '{1'b0, 1'b0, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h5555, 16'h6666, 16'h5555, 16'h6666, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, 1'b1};
    for (int i = 6; i < 13; i++)
      vecs[i] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 16'h2222, 16'h1111, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 16'habcd, 16'h1234, 16'h1234, 16'habcd, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].req, vecs[i].fs, vecs[i].a, vecs[i].b);
      $display("vec %0d: req=%b fs=%b a=%h b=%h -> x=%h y=%h ss=%b busy=%b",
               i, vecs[i].req, vecs[i].fs, vecs[i].a, vecs[i].b, sw.x, sw.y, sw.switch_state, sw.busy);
      chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ess, vecs[i].ebusy);
    end

    // Request withdrawn before any frame_start: no mute, no swap.
    do_reset();
    cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    chk_all("cancel.arm", 16'h1111, 16'h2222, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    cycle(1'b0, 1'b0, 16'h7777, 16'h8888);
    chk_all("cancel.drop", 16'h7777, 16'h8888, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h1111, 16'h2222);
    chk_all("cancel.after", 16'h1111, 16'h2222, 1'b0, 1'b0);
    $display("seq cancel: ss=%b busy=%b", sw.switch_state, sw.busy);

    // Drop coinciding with frame_start: cancel wins.
    do_reset();
    cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    cycle(1'b0, 1'b1, 16'h1111, 16'h2222);
    chk_all("cancelfs.edge", 16'h1111, 16'h2222, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h1111, 16'h2222);
    chk_all("cancelfs.next", 16'h1111, 16'h2222, 1'b0, 1'b0);
    $display("seq cancel_on_fs: ss=%b busy=%b", sw.switch_state, sw.busy);

    // Request toggled back during MUTE: swap completes, then re-arms.
    do_reset();
    cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    cycle(1'b1, 1'b1, 16'h1111, 16'h2222);
    for (int i = 0; i < M; i++) begin
      cycle(1'b0, 1'b0, 16'h1111, 16'h2222);
      chk_all($sformatf("toggle.mute1_%0d", i), 16'h0, 16'h0, i == M - 1, i != M - 1);
    end
    cycle(1'b0, 1'b0, 16'h1111, 16'h2222);
    chk_all("toggle.rearm", 16'h2222, 16'h1111, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h1111, 16'h2222);
    chk_all("toggle.fs", 16'h2222, 16'h1111, 1'b1, 1'b1);
    for (int i = 0; i < M; i++) begin
      cycle(1'b0, 1'b0, 16'h1111, 16'h2222);
      chk_all($sformatf("toggle.mute2_%0d", i), 16'h0, 16'h0, i != M - 1, i != M - 1);
    end
    cycle(1'b0, 1'b0, 16'h1111, 16'h2222);
    chk_all("toggle.done", 16'h1111, 16'h2222, 1'b0, 1'b0);
    $display("seq toggle_in_mute: ss=%b busy=%b", sw.switch_state, sw.busy);

    // Reset asserted at mute cycle 3, then released with the request high.
    do_reset();
    cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    cycle(1'b1, 1'b1, 16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    chk_all("rstmute.before", 16'h0, 16'h0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_all("rstmute.async", 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 16'h1111, 16'h2222);
    chk_all("rstmute.rearm", 16'h1111, 16'h2222, 1'b0, 1'b1);
    $display("seq reset_in_mute: ss=%b busy=%b", sw.switch_state, sw.busy);

    // Randomized run against the model.
    do_reset();
    rreq = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) rreq = ~rreq;
      rfs = ($urandom_range(0, 9) == 0);
      ra  = DW'($urandom);
      rb  = DW'($urandom);
      drive(rreq, rfs, ra, rb);
      model_step(rreq, rfs, ra, rb, rx, ry, ress, rbusy);
      @(posedge clk);
      #1;
      $display("rnd %0d: req=%b fs=%b a=%h b=%h -> x=%h y=%h ss=%b busy=%b",
               n, rreq, rfs, ra, rb, sw.x, sw.y, sw.switch_state, sw.busy);
      chk_all($sformatf("rnd%0d", n), rx, ry, ress, rbusy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
